// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU: holds dispatched ops until both
// operands are captured (at dispatch or from the ALU/LSB CDBs) and issues one per cycle.
module alu_rs #(
  parameter int RS_SIZE      = 8,
  parameter int ROB_ID_WIDTH = 3,
  parameter int OP_WIDTH     = 7,
  parameter int VAL_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_in,
  input  logic                    disp_valid,
  input  logic [OP_WIDTH-1:0]     disp_op,
  input  logic                    disp_rs1_rdy,
  input  logic [VAL_WIDTH-1:0]    disp_rs1_val,
  input  logic [ROB_ID_WIDTH:0]   disp_rs1_tag,
  input  logic                    disp_rs2_rdy,
  input  logic [VAL_WIDTH-1:0]    disp_rs2_val,
  input  logic [ROB_ID_WIDTH:0]   disp_rs2_tag,
  input  logic [ROB_ID_WIDTH:0]   disp_entry,
  input  logic [ADDR_WIDTH-1:0]   disp_pc,
  output logic                    rs_full,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_ID_WIDTH:0]   alu_cdb_entry,
  input  logic [VAL_WIDTH-1:0]    alu_cdb_val,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb_entry,
  input  logic [VAL_WIDTH-1:0]    lsb_cdb_val,
  output logic                    execute,
  output logic [OP_WIDTH-1:0]     op_type,   // issued op ("type" is a reserved word)
  output logic [VAL_WIDTH-1:0]    val1,
  output logic [VAL_WIDTH-1:0]    val2,
  output logic [ROB_ID_WIDTH:0]   entry,
  output logic [ADDR_WIDTH-1:0]   nowPC
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int TAG_W = ROB_ID_WIDTH + 1;

  logic [RS_SIZE-1:0]    busy_reg;
  logic [RS_SIZE-1:0]    rdy1_reg;
  logic [RS_SIZE-1:0]    rdy2_reg;
  logic [OP_WIDTH-1:0]   op_reg  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  v1_reg  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  v2_reg  [RS_SIZE];
  logic [TAG_W-1:0]      t1_reg  [RS_SIZE];
  logic [TAG_W-1:0]      t2_reg  [RS_SIZE];
  logic [TAG_W-1:0]      dst_reg [RS_SIZE];
  logic [ADDR_WIDTH-1:0] pc_reg  [RS_SIZE];

  logic [RS_SIZE-1:0]    ready_vec;
  logic [RS_SIZE-1:0]    w1_rdy;
  logic [RS_SIZE-1:0]    w2_rdy;
  logic [VAL_WIDTH-1:0]  w1_val [RS_SIZE];
  logic [VAL_WIDTH-1:0]  w2_val [RS_SIZE];

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W:0]        busy_cnt;
  logic                  d1_rdy;
  logic                  d2_rdy;
  logic [VAL_WIDTH-1:0]  d1_val;
  logic [VAL_WIDTH-1:0]  d2_val;

  // Eligibility uses registered state only, so a wakeup takes effect next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_ready
      assign ready_vec[gi] = busy_reg[gi] & rdy1_reg[gi] & rdy2_reg[gi];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w1_rdy[i] = rdy1_reg[i];
      w1_val[i] = v1_reg[i];
      w2_rdy[i] = rdy2_reg[i];
      w2_val[i] = v2_reg[i];
      if (!rdy1_reg[i]) begin
        if (alu_cdb_valid && alu_cdb_entry == t1_reg[i]) begin
          w1_rdy[i] = 1'b1;
          w1_val[i] = alu_cdb_val;
        end else if (lsb_cdb_valid && lsb_cdb_entry == t1_reg[i]) begin
          w1_rdy[i] = 1'b1;
          w1_val[i] = lsb_cdb_val;
        end
      end
      if (!rdy2_reg[i]) begin
        if (alu_cdb_valid && alu_cdb_entry == t2_reg[i]) begin
          w2_rdy[i] = 1'b1;
          w2_val[i] = alu_cdb_val;
        end else if (lsb_cdb_valid && lsb_cdb_entry == t2_reg[i]) begin
          w2_rdy[i] = 1'b1;
          w2_val[i] = lsb_cdb_val;
        end
      end
    end
  end

  // Same-cycle CDB bypass for operands that arrive pending at dispatch.
  always_comb begin
    d1_rdy = disp_rs1_rdy;
    d1_val = disp_rs1_val;
    d2_rdy = disp_rs2_rdy;
    d2_val = disp_rs2_val;
    if (!disp_rs1_rdy) begin
      if (alu_cdb_valid && alu_cdb_entry == disp_rs1_tag) begin
        d1_rdy = 1'b1;
        d1_val = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_entry == disp_rs1_tag) begin
        d1_rdy = 1'b1;
        d1_val = lsb_cdb_val;
      end
    end
    if (!disp_rs2_rdy) begin
      if (alu_cdb_valid && alu_cdb_entry == disp_rs2_tag) begin
        d2_rdy = 1'b1;
        d2_val = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_entry == disp_rs2_tag) begin
        d2_rdy = 1'b1;
        d2_val = lsb_cdb_val;
      end
    end
  end

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    busy_cnt   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      busy_cnt = busy_cnt + {{IDX_W{1'b0}}, busy_reg[i]};
    end
  end

  assign rs_full = (busy_cnt == (IDX_W+1)'(RS_SIZE)) ||
                   ((busy_cnt == (IDX_W+1)'(RS_SIZE - 1)) && disp_valid);

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      busy_reg <= '0;
      execute  <= 1'b0;
      op_type  <= '0;
      val1     <= '0;
      val2     <= '0;
      entry    <= '0;
      nowPC    <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy_reg <= '0;
        execute  <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_reg[i]) begin
            rdy1_reg[i] <= w1_rdy[i];
            v1_reg[i]   <= w1_val[i];
            rdy2_reg[i] <= w2_rdy[i];
            v2_reg[i]   <= w2_val[i];
          end
        end
        // The selected slot is busy and the free slot is not, so they never collide.
        if (sel_found) begin
          execute           <= 1'b1;
          op_type           <= op_reg[sel_idx];
          val1              <= v1_reg[sel_idx];
          val2              <= v2_reg[sel_idx];
          entry             <= dst_reg[sel_idx];
          nowPC             <= pc_reg[sel_idx];
          busy_reg[sel_idx] <= 1'b0;
        end else begin
          execute <= 1'b0;
        end
        if (disp_valid && free_found) begin
          busy_reg[free_idx] <= 1'b1;
          op_reg[free_idx]   <= disp_op;
          rdy1_reg[free_idx] <= d1_rdy;
          v1_reg[free_idx]   <= d1_val;
          t1_reg[free_idx]   <= disp_rs1_tag;
          rdy2_reg[free_idx] <= d2_rdy;
          v2_reg[free_idx]   <= d2_val;
          t2_reg[free_idx]   <= disp_rs2_tag;
          dst_reg[free_idx]  <= disp_entry;
          pc_reg[free_idx]   <= disp_pc;
        end
      end
    end
  end

endmodule
